axis_sram_packer: RTL and testbench

Parametrised AXI4-Stream to SRAM-word packer. It sits between the input arbiter and the SRAM output-queue controller in the same clock domain. Each packet becomes one header word carrying `tuser`, followed by `C_S_AXIS_DATA_WIDTH/C_MEM_DATA_WIDTH` memory slices per beat. Each slice is tagged with SOP/EOP, a valid-byte count and a destination-queue mask. Packets with no destination queue are dropped and counted.

---
 rtl/axis_sram_pkg.sv | 43 ++++
 rtl/axis_sram_slice_sel.sv | 43 ++++
 rtl/axis_sram_packer.sv | 199 +++++++++++++++++++
 tb/tb_axis_sram_packer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sram_pkg.sv
// Shared definitions for the AXI4-Stream to SRAM-word packer: dout field layout,
// tuser destination offset, FSM state encoding and small constant helpers.
package axis_sram_pkg;

  localparam int PAYLOAD_LSB   = 0;
  localparam int TUSER_DST_LSB = 24;
  localparam int POP_MAX_W     = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // dout is {sop, eop, bcnt, payload}, MSB first
  function automatic int bcnt_lsb(input int mem_w);
    return PAYLOAD_LSB + mem_w;
  endfunction

  function automatic int eop_bit(input int mem_w, input int bcnt_w);
    return bcnt_lsb(mem_w) + bcnt_w;
  endfunction

  function automatic int sop_bit(input int mem_w, input int bcnt_w);
    return eop_bit(mem_w, bcnt_w) + 1;
  endfunction

  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/axis_sram_slice_sel.sv
// Selects one memory slice from the held beat and reports its byte count and
// whether it is the last slice to emit for that beat.
module axis_sram_slice_sel
  import axis_sram_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_MEM_DATA_WIDTH    = 128,
  localparam int R      = C_S_AXIS_DATA_WIDTH / C_MEM_DATA_WIDTH,
  localparam int IDX_W  = (R > 1) ? clog2(R) : 1,
  localparam int BCNT_W = clog2(C_MEM_DATA_WIDTH / 8 + 1)
) (
  input  logic [IDX_W-1:0]                 idx,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   hold_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] hold_tstrb,
  input  logic                             hold_tlast,
  output logic [C_MEM_DATA_WIDTH-1:0]      slice_data,
  output logic [BCNT_W-1:0]                slice_bcnt,
  output logic                             is_final
);

  localparam int SB = C_MEM_DATA_WIDTH / 8;

  logic [SB-1:0]        slice_strb;
  logic [POP_MAX_W-1:0] pop_in;
  logic [IDX_W-1:0]     last_idx;

  always_comb begin
    slice_data = hold_tdata[int'(idx)*C_MEM_DATA_WIDTH +: C_MEM_DATA_WIDTH];
    slice_strb = hold_tstrb[int'(idx)*SB +: SB];
    pop_in     = '0;
    pop_in[SB-1:0] = slice_strb;
    slice_bcnt = BCNT_W'(popcount(pop_in));

    // highest slice holding any valid byte; slice 0 if the strobe is empty
    last_idx = '0;
    for (int s = 0; s < R; s++) begin
      if (|hold_tstrb[s*SB +: SB]) last_idx = IDX_W'(s);
    end

    is_final = hold_tlast ? (idx == last_idx) : (int'(idx) == R - 1);
  end

endmodule

// File: rtl/axis_sram_packer.sv
// AXI4-Stream to SRAM-word packer: one header word per packet, then one tagged
// word per memory slice; packets without a destination queue are dropped.
//   state | meaning
//   IDLE  | waiting for the first beat of a packet
//   HDR   | emitting the header word built from tuser
//   DATA  | emitting slices of the held beat
//   DROP  | swallowing beats of a packet with an empty queue mask
module axis_sram_packer
  import axis_sram_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_MEM_DATA_WIDTH     = 128,
  parameter int C_NUM_QUEUES         = 5,
  localparam int BCNT_W = clog2(C_MEM_DATA_WIDTH / 8 + 1),
  localparam int DOUT_W = C_MEM_DATA_WIDTH + 2 + BCNT_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tvalid,
  output logic                              tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser,
  input  logic                              tlast,
  output logic [DOUT_W-1:0]                 dout,
  output logic                              dout_valid,
  output logic [C_NUM_QUEUES-1:0]           oq,
  input  logic                              memfull,
  output logic [31:0]                       drop_count
);

  localparam int R        = C_S_AXIS_DATA_WIDTH / C_MEM_DATA_WIDTH;
  localparam int IDX_W    = (R > 1) ? clog2(R) : 1;
  localparam int SOP_BIT  = sop_bit(C_MEM_DATA_WIDTH, BCNT_W);
  localparam int EOP_BIT  = eop_bit(C_MEM_DATA_WIDTH, BCNT_W);
  localparam int BCNT_LSB = bcnt_lsb(C_MEM_DATA_WIDTH);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic                              hold_valid;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    hold_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  hold_tstrb;
  logic                              hold_tlast;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser_q;
  logic [C_NUM_QUEUES-1:0]           mask_q;
  logic [C_NUM_QUEUES-1:0]           mask_in;

  logic [C_MEM_DATA_WIDTH-1:0] slice_data;
  logic [BCNT_W-1:0]           slice_bcnt;
  logic                        is_final;

  logic accept, emit, emit_hdr, hold_load, hold_clear, mask_load, pkt_start, drop_inc;
  logic [DOUT_W-1:0] dout_d;

  axis_sram_slice_sel #(
    .C_S_AXIS_DATA_WIDTH (C_S_AXIS_DATA_WIDTH),
    .C_MEM_DATA_WIDTH    (C_MEM_DATA_WIDTH)
  ) u_slice_sel (
    .idx        (idx_q),
    .hold_tdata (hold_tdata),
    .hold_tstrb (hold_tstrb),
    .hold_tlast (hold_tlast),
    .slice_data (slice_data),
    .slice_bcnt (slice_bcnt),
    .is_final   (is_final)
  );

  assign mask_in = tuser[TUSER_DST_LSB +: C_NUM_QUEUES];

  always_comb begin
    tready = !reset && (state_q != ST_HDR) &&
             ((state_q == ST_IDLE) || (state_q == ST_DROP) || !hold_valid ||
              ((state_q == ST_DATA) && is_final && !memfull));
  end

  assign accept = tvalid && tready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    emit       = 1'b0;
    emit_hdr   = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    mask_load  = 1'b0;
    pkt_start  = 1'b0;
    drop_inc   = 1'b0;

    case (state_q)
      ST_IDLE: pkt_start = accept;
      ST_HDR: begin
        if (!memfull) begin
          emit     = 1'b1;
          emit_hdr = 1'b1;
          idx_d    = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!hold_valid) begin
          hold_load = accept;
        end else if (!memfull) begin
          emit = 1'b1;
          if (is_final) begin
            idx_d = '0;
            if (hold_tlast) begin
              // a beat accepted alongside the eop slice opens the next packet
              state_d    = ST_IDLE;
              hold_clear = 1'b1;
              pkt_start  = accept;
            end else if (accept) begin
              hold_load = 1'b1;
            end else begin
              hold_clear = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DROP: begin
        if (accept && tlast) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pkt_start) begin
      if (mask_in != '0) begin
        state_d   = ST_HDR;
        hold_load = 1'b1;
        mask_load = 1'b1;
      end else if (tlast) begin
        state_d  = ST_IDLE;
        drop_inc = 1'b1;
      end else begin
        state_d = ST_DROP;
      end
    end
  end

  always_comb begin
    dout_d = '0;
    if (emit_hdr) begin
      dout_d[SOP_BIT] = 1'b1;
      dout_d[PAYLOAD_LSB +: C_S_AXIS_TUSER_WIDTH] = tuser_q;
    end else begin
      dout_d[EOP_BIT] = hold_tlast && is_final;
      dout_d[BCNT_LSB +: BCNT_W] = slice_bcnt;
      dout_d[PAYLOAD_LSB +: C_MEM_DATA_WIDTH] = slice_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      hold_valid <= 1'b0;
      hold_tdata <= '0;
      hold_tstrb <= '0;
      hold_tlast <= 1'b0;
      tuser_q    <= '0;
      mask_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      oq         <= '0;
      drop_count <= '0;
    end else begin
      idx_q <= idx_d;
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_tdata <= tdata;
        hold_tstrb <= tstrb;
        hold_tlast <= tlast;
      end else if (hold_clear) begin
        hold_valid <= 1'b0;
      end
      if (mask_load) begin
        mask_q  <= mask_in;
        tuser_q <= tuser;
      end
      dout_valid <= emit;
      if (emit) begin
        dout <= dout_d;
        oq   <= mask_q;
      end
      if (drop_inc && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_sram_packer.sv
// Bench for axis_sram_packer: directed scenarios plus randomized packets, each
// checked against a packet-level model of the expected SRAM word stream.
`timescale 1ns/1ps
module tb_axis_sram_packer;

  localparam int DW  = 256;
  localparam int TW  = 128;
  localparam int MW  = 128;
  localparam int NQ  = 5;
  localparam int SB  = DW / 8;
  localparam int BCW = 5;
  localparam int DOW = MW + 2 + BCW;
  localparam int OW  = NQ + DOW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tvalid = 1'b0;
  logic           tready;
  logic [DW-1:0]  tdata = '0;
  logic [SB-1:0]  tstrb = '0;
  logic [TW-1:0]  tuser = '0;
  logic           tlast = 1'b0;
  logic [DOW-1:0] dout;
  logic           dout_valid;
  logic [NQ-1:0]  oq;
  logic           memfull = 1'b0;
  logic [31:0]    drop_count;

  always #5 clk = ~clk;

  axis_sram_packer dut (
    .clk        (clk),
    .reset      (reset),
    .tvalid     (tvalid),
    .tready     (tready),
    .tdata      (tdata),
    .tstrb      (tstrb),
    .tuser      (tuser),
    .tlast      (tlast),
    .dout       (dout),
    .dout_valid (dout_valid),
    .oq         (oq),
    .memfull    (memfull),
    .drop_count (drop_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_drops = 0;

  // observed words {oq, dout} with the cycle they appeared in
  logic [OW-1:0] obs_q[$];
  int            obs_cyc[$];
  logic [OW-1:0] exp_q[$];
  int            cyc = 0;
  int            mf_viol = 0;
  logic          mf_s = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    mf_s <= memfull;
  end

  always @(negedge clk) begin
    if (dout_valid) begin
      obs_q.push_back({oq, dout});
      obs_cyc.push_back(cyc);
      if (mf_s) mf_viol <= mf_viol + 1;
    end
  end

  logic [DW-1:0] pkt_data[8];
  logic [SB-1:0] pkt_strb[8];
  logic [TW-1:0] pkt_user;
  int            pkt_nb;

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic make_pkt(input logic [7:0] dst, input int nb, input logic [SB-1:0] last_strb);
    pkt_nb   = nb;
    pkt_user = {$urandom, $urandom, $urandom, $urandom};
    pkt_user[31:24] = dst;
    for (int b = 0; b < nb; b++) begin
      pkt_data[b] = rand256();
      pkt_strb[b] = (b == nb - 1) ? last_strb : '1;
    end
  endtask

  // Expected words: header, then every slice of full beats, and on the last
  // beat only up to the highest slice with a valid byte (slice 0 if none).
  task automatic model_pkt();
    logic [NQ-1:0] m;
    int ns;
    logic [15:0] ss;
    m = pkt_user[24 +: NQ];
    if (m == '0) begin
      exp_drops++;
      return;
    end
    exp_q.push_back({m, 1'b1, 1'b0, 5'd0, pkt_user});
    for (int b = 0; b < pkt_nb; b++) begin
      if (b < pkt_nb - 1) ns = 2;
      else begin
        ns = 1;
        if (pkt_strb[b][31:16] != 16'h0) ns = 2;
      end
      for (int s = 0; s < ns; s++) begin
        ss = pkt_strb[b][16*s +: 16];
        exp_q.push_back({m, 1'b0, (b == pkt_nb - 1) && (s == ns - 1),
                         5'($countones(ss)), pkt_data[b][MW*s +: MW]});
      end
    end
  endtask

  task automatic wait_accept();
    int n = 0;
    logic acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL handshake_timeout: tready stayed 0 for %0d cycles, want accept", n);
    end
  endtask

  task automatic send_pkt(input int gap_max);
    for (int b = 0; b < pkt_nb; b++) begin
      if (gap_max > 0) begin
        int g = $urandom_range(0, gap_max);
        if (g > 0) begin
          tvalid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
      tvalid = 1'b1;
      tdata  = pkt_data[b];
      tstrb  = pkt_strb[b];
      tuser  = (b == 0) ? pkt_user : {$urandom, $urandom, $urandom, $urandom};
      tlast  = (b == pkt_nb - 1);
      wait_accept();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (dout_valid !== 1'b0) $display("FAIL rst_dout_valid: got %b want 0", dout_valid); else n_pass++;
    n_checks++; if (dout !== '0) $display("FAIL rst_dout: got %h want 0", dout); else n_pass++;
    n_checks++; if (oq !== '0) $display("FAIL rst_oq: got %b want 0", oq); else n_pass++;
    n_checks++; if (drop_count !== 32'd0) $display("FAIL rst_drop_count: got %0d want 0", drop_count); else n_pass++;
    n_checks++; if (tready !== 1'b0) $display("FAIL rst_tready_in_reset: got %b want 0", tready); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (tready !== 1'b1) $display("FAIL rst_tready_after: got %b want 1", tready); else n_pass++;
    @(posedge clk);
    #1;
    exp_drops = 0;
  endtask

  task automatic test_full_strobe();
    clear_sb();
    make_pkt(8'h04, 2, '1);
    model_pkt();
    send_pkt(0);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL fs_count: got %0d words want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL fs_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    if (obs_q.size() == 5) begin
      n_checks++; if (obs_q[0][OW-1 -: NQ] !== 5'b00100) $display("FAIL fs_hdr_oq: got %b want 00100", obs_q[0][OW-1 -: NQ]); else n_pass++;
      n_checks++; if (obs_q[0][DOW-1] !== 1'b1) $display("FAIL fs_hdr_sop: got %b want 1", obs_q[0][DOW-1]); else n_pass++;
      n_checks++; if (obs_q[4][DOW-2] !== 1'b1) $display("FAIL fs_eop: got %b want 1", obs_q[4][DOW-2]); else n_pass++;
      n_checks++; if (obs_cyc[4] - obs_cyc[0] != 4) $display("FAIL fs_consecutive: got span %0d want 4", obs_cyc[4] - obs_cyc[0]); else n_pass++;
    end
  endtask

  task automatic test_partial_last();
    clear_sb();
    make_pkt(8'h02, 2, 32'h0000_00FF);
    model_pkt();
    send_pkt(0);
    drain();
    n_checks++; if (obs_q.size() != 4) $display("FAIL pl_count: got %0d words want 4", obs_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL pl_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    if (obs_q.size() == 4) begin
      n_checks++; if (obs_q[3][DOW-3 -: BCW] !== 5'd8) $display("FAIL pl_last_bcnt: got %0d want 8", obs_q[3][DOW-3 -: BCW]); else n_pass++;
      n_checks++; if (obs_q[3][DOW-2] !== 1'b1) $display("FAIL pl_last_eop: got %b want 1", obs_q[3][DOW-2]); else n_pass++;
    end
  endtask

  task automatic test_drop();
    clear_sb();
    n_checks++; if (drop_count !== 32'd0) $display("FAIL drop_before: got %0d want 0", drop_count); else n_pass++;
    make_pkt(8'h00, 3, '1);
    model_pkt();
    send_pkt(0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (obs_q.size() != 0) $display("FAIL drop_words: got %0d words want 0", obs_q.size()); else n_pass++;
    n_checks++; if (drop_count !== 32'd1) $display("FAIL drop_after: got %0d want 1", drop_count); else n_pass++;
    make_pkt(8'h01, 2, 32'h0003_FFFF);
    model_pkt();
    send_pkt(0);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL drop_next_count: got %0d words want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL drop_next_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int bad_v = 0;
    int bad_r = 0;
    int v0;
    clear_sb();
    v0 = mf_viol;
    make_pkt(8'h08, 4, '1);
    model_pkt();
    fork
      send_pkt(0);
      begin
        int n = 0;
        while (obs_q.size() < 3 && n < 200) begin
          @(posedge clk);
          n++;
        end
        @(posedge clk);
        #1 memfull = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(posedge clk);
          #1;
          if (dout_valid) bad_v++;
          if (tready) bad_r++;
        end
        memfull = 1'b0;
      end
    join
    drain();
    n_checks++; if (bad_v != 0) $display("FAIL stall_valid: got %0d valid cycles want 0", bad_v); else n_pass++;
    n_checks++; if (bad_r != 0) $display("FAIL stall_tready: got %0d ready cycles want 0", bad_r); else n_pass++;
    n_checks++; if (mf_viol != v0) $display("FAIL stall_memfull_emit: got %0d words after memfull want 0", mf_viol - v0); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d words want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL stall_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    make_pkt(8'h02, 4, '1);
    tvalid = 1'b1;
    tdata  = pkt_data[0];
    tstrb  = pkt_strb[0];
    tuser  = pkt_user;
    tlast  = 1'b0;
    wait_accept();
    tvalid = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (dout_valid !== 1'b0) $display("FAIL rm_dout_valid: got %b want 0", dout_valid); else n_pass++;
    n_checks++; if (dout !== '0) $display("FAIL rm_dout: got %h want 0", dout); else n_pass++;
    n_checks++; if (oq !== '0) $display("FAIL rm_oq: got %b want 0", oq); else n_pass++;
    n_checks++; if (drop_count !== 32'd0) $display("FAIL rm_drop_count: got %0d want 0", drop_count); else n_pass++;
    n_checks++; if (tready !== 1'b0) $display("FAIL rm_tready: got %b want 0", tready); else n_pass++;
    reset = 1'b0;
    exp_drops = 0;
    @(posedge clk);
    #1;
    n_checks++; if (obs_q.size() != 0) $display("FAIL rm_no_words: got %0d words want 0", obs_q.size()); else n_pass++;
    make_pkt(8'h02, 3, 32'h0000_0FFF);
    model_pkt();
    send_pkt(0);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rm_count: got %0d words want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0][DOW-1] !== 1'b1) $display("FAIL rm_first_sop: got %b want 1", obs_q[0][DOW-1]); else n_pass++;
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rm_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n1;
    int sops = 0;
    clear_sb();
    make_pkt(8'h03, 2, 32'h0007_FFFF);
    model_pkt();
    n1 = exp_q.size();
    send_pkt(0);
    make_pkt(8'h10, 2, '1);
    model_pkt();
    send_pkt(0);
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d words want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
      n_checks++;
      if (obs_q[i][OW-1 -: NQ] !== ((i < n1) ? 5'b00011 : 5'b10000))
        $display("FAIL b2b_oq%0d: got %b want %b", i, obs_q[i][OW-1 -: NQ], (i < n1) ? 5'b00011 : 5'b10000);
      else n_pass++;
      if (obs_q[i][DOW-1]) sops++;
    end
    n_checks++; if (sops != 2) $display("FAIL b2b_headers: got %0d sop words want 2", sops); else n_pass++;
    if (obs_q.size() == exp_q.size() && obs_q.size() > 0) begin
      n_checks++;
      if (obs_cyc[obs_cyc.size()-1] - obs_cyc[0] != obs_q.size() - 1)
        $display("FAIL b2b_gapless: got span %0d want %0d", obs_cyc[obs_cyc.size()-1] - obs_cyc[0], obs_q.size() - 1);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic done = 1'b0;
    int v0;
    clear_sb();
    v0 = mf_viol;
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          int k = $urandom_range(0, 32);
          logic [7:0] dst = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
          make_pkt(dst, $urandom_range(1, 4), (k == 32) ? '1 : ((32'h1 << k) - 32'h1));
          model_pkt();
          send_pkt(2);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 memfull = ($urandom_range(0, 3) == 0);
        end
        memfull = 1'b0;
      end
    join
    drain();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d words want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rnd_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (drop_count !== 32'(exp_drops)) $display("FAIL rnd_drop_count: got %0d want %0d", drop_count, exp_drops); else n_pass++;
    n_checks++; if (mf_viol != v0) $display("FAIL rnd_memfull_emit: got %0d words after memfull want 0", mf_viol - v0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_strobe();
    test_partial_last();
    test_drop();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
